// File: rtl/mult_div_unit.sv
// mult_div_unit: 34-cycle radix-2 MULT/MULTU/DIV/DIVU into HI/LO; define MTHI_MTLO_EN for the MTHI/MTLO write path
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [1:0]            MDOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
`ifdef MTHI_MTLO_EN
    input  logic                  WriteHI,
    input  logic                  WriteLO,
    input  logic [DATA_WIDTH-1:0] WriteData,
`endif
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic           is_div, sa, sb, start_ok, dz;
    logic [W-1:0]   m, a_abs, b_abs, quo, rem, q_fix, r_fix;
    logic [2*W-1:0] acc, prod_fix;
    logic [W:0]     add_sum, shl, diff;

    assign start_ok = state == IDLE && Start;
    assign Busy     = state != IDLE;
    assign a_abs    = (!MDOperation[0] && A[W-1]) ? -A : A;
    assign b_abs    = (!MDOperation[0] && B[W-1]) ? -B : B;

    always_comb begin
        state_n = (state == IDLE) ? (Start ? RUN : IDLE) :
                  (state == RUN)  ? ((cnt == '0) ? FIX : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // acc is the product accumulator for multiply and {remainder, quotient} for divide
    always_comb begin
        add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : '0);
        shl      = {acc[2*W-1:W], acc[W-1]};
        diff     = shl - {1'b0, m};
        quo      = acc[W-1:0];
        rem      = acc[2*W-1:W];
        dz       = is_div && m == '0;
        prod_fix = (sa ^ sb) ? -acc : acc;
        q_fix    = dz ? '1 : ((sa ^ sb) ? -quo : quo);
        r_fix    = sa ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            is_div    <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            m         <= '0;
            acc       <= '0;
            HI        <= '0;
            LO        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= state == FIX;
            DivByZero <= state == FIX && dz;
            if (start_ok) begin
                cnt    <= CW'(W - 1);
                is_div <= MDOperation[1];
                sa     <= !MDOperation[0] && A[W-1];
                sb     <= !MDOperation[0] && B[W-1];
                m      <= b_abs;
                acc    <= {{W{1'b0}}, a_abs};
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
                acc <= !is_div ? {add_sum, acc[W-1:1]} :
                       diff[W] ? {shl[W-1:0], acc[W-2:0], 1'b0} :
                                 {diff[W-1:0], acc[W-2:0], 1'b1};
            end else if (state == FIX) begin
                HI <= is_div ? r_fix : prod_fix[2*W-1:W];
                LO <= is_div ? q_fix : prod_fix[W-1:0];
            end
`ifdef MTHI_MTLO_EN
            else begin
                if (WriteHI) HI <= WriteData;
                if (WriteLO) LO <= WriteData;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  MDOperation = 2'd0;
    logic [31:0] A = '0, B = '0;
    logic        WriteHI = 1'b0, WriteLO = 1'b0;
    logic [31:0] WriteData = '0;
    logic        Busy, Done, DivByZero;
    logic [31:0] HI, LO;
    int          total = 0;
    int          bad = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOperation(MDOperation), .A(A), .B(B),
`ifdef MTHI_MTLO_EN
        .WriteHI(WriteHI), .WriteLO(WriteLO), .WriteData(WriteData),
`endif
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        int sa, sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        if (op == 2'd0) {hi, lo} = longint'(sa) * longint'(sb);
        else if (op == 2'd1) {hi, lo} = {32'b0, a} * {32'b0, b};
        else if (b == 0) begin
            lo = '1;
            hi = a;
            dz = 1'b1;
        end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = a;
            hi = '0;
        end else if (op == 2'd2) begin
            lo = sa / sb;
            hi = sa % sb;
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Enters in an IDLE cycle, returns in the Done cycle; poke re-raises Start at that busy cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, input string tag);
        logic [31:0] eh, el;
        logic        ed;
        int          busy_bad;
        model(op, a, b, eh, el, ed);
        Start = 1'b1;
        MDOperation = op;
        A = a;
        B = b;
        step();
        A = $urandom;
        B = $urandom;
        MDOperation = 2'($urandom);
        busy_bad = 0;
        for (int c = 1; c <= 33; c++) begin
            if (Busy !== 1'b1 || Done !== 1'b0 || DivByZero !== 1'b0) busy_bad++;
            Start = (c == poke);
            step();
        end
        Start = 1'b0;
        check({tag, "_busywin"}, 64'(busy_bad), 64'd0);
        check({tag, "_done"}, {62'd0, Done, Busy}, 64'd2);
        check({tag, "_hilo"}, {HI, LO}, {eh, el});
        check({tag, "_dz"}, 64'(DivByZero), 64'(ed));
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (Done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int          nd;
        logic [1:0]  op;
        logic [31:0] ra, rb;
        step();
        step();
        reset = 1'b1;
        check("reset_state", {59'd0, Busy, Done, DivByZero, 2'd0}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        check("multu_max_val", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        step();
        check("after_done", {62'd0, Done, DivByZero}, 64'd0);

        do_op(2'd0, 32'hFFFF_FFF9, 32'd3, 0, "mult_neg");
        check("mult_neg_val", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        step();
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
        check("div_neg_val", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        check("div_ovf_val", {HI, LO, 31'd0, DivByZero}, {64'h0000_0000_8000_0000, 32'd0});
        step();
        do_op(2'd3, 32'd100, 32'd0, 0, "divu_zero");
        check("divu_zero_val", {HI, LO}, {32'd100, 32'hFFFF_FFFF});
        step();
        check("dz_one_cycle", 64'(DivByZero), 64'd0);
        do_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0, "div_zero_neg");
        step();

        do_op(2'd0, 32'd6, 32'd7, 5, "busy_start");
        count_done(40, nd);
        check("busy_start_ignored", 64'(nd), 64'd0);

        do_op(2'd1, 32'd12345, 32'd678, 0, "chain1");
        do_op(2'd3, 32'd1000, 32'd7, 0, "chain2");
        step();
        check("chain_drop", 64'(Done), 64'd0);

        Start = 1'b1;
        MDOperation = 2'd1;
        A = 32'd9;
        B = 32'd9;
        step();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        reset = 1'b0;
        step();
        check("midrun_reset1", {HI, LO, 29'd0, Busy, Done, DivByZero}, 96'd0);
        step();
        reset = 1'b1;
        check("midrun_reset2", {HI, LO, 29'd0, Busy, Done, DivByZero}, 96'd0);
        count_done(40, nd);
        check("midrun_no_done", 64'(nd), 64'd0);
        check("midrun_hilo_kept", {HI, LO}, 64'd0);

`ifdef MTHI_MTLO_EN
        WriteHI = 1'b1;
        WriteData = 32'h1234;
        step();
        WriteHI = 1'b0;
        check("mthi", 64'(HI), 64'h1234);
        WriteHI = 1'b1;
        WriteLO = 1'b1;
        WriteData = 32'hDEAD;
        Start = 1'b1;
        MDOperation = 2'd1;
        A = 32'd2;
        B = 32'd3;
        step();
        Start = 1'b0;
        WriteData = 32'hBEEF;
        for (int c = 1; c <= 33; c++) step();
        check("mthi_busy_ignored", {HI, LO}, {32'h1234, 32'd0});
        WriteHI = 1'b0;
        WriteLO = 1'b0;
        step();
        check("mthi_then_op", {62'd0, Done, Busy}, 64'd2);
        check("mthi_op_val", {HI, LO}, 64'd6);
        step();
`endif

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = rb >> 24;
                1: ra = ra >> 20;
                2: rb = (op[1] && i % 2 == 0) ? 32'd0 : -(rb >> 28);
                default: ;
            endcase
            do_op(op, ra, rb, 0, "rand");
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
